// File: rtl/id_ex_stage.sv
// id_ex_stage -- one-entry ID/EX pipeline register with load-use stall and
// operand forwarding.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   decode-side handshake
//   pc, imm, rs1_data, rs2_data, rs1_addr, rs2_addr, rd_addr, alu_ctrl_in,
//   use_pc, use_imm, reg_write, mem_read
//                       decoded instruction fields captured on accept
//   flush               discard the held entry (branch redirect)
//   exm_*               EX/MEM producer (forwarding source, load-use check)
//   mwb_*               MEM/WB producer (forwarding source, held-data refresh)
//   out_valid/out_ready ALU-side handshake
//   alu_a, alu_b, alu_ctrl, rd_out, reg_write_out, mem_read_out, pc_out
//                       operands and control for EX
//   stall_cnt           saturating count of clock edges spent stalled
//   state_dbg           current FSM state (debug visibility)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. out_valid never depends on out_ready; in_ready depends on
// out_ready only in FULL, where a drain and a refill happen on the same edge.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [3:0]  alu_ctrl_in,
  input  logic        use_pc,
  input  logic        use_imm,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        flush,
  input  logic        exm_reg_write,
  input  logic        exm_mem_read,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mwb_reg_write,
  input  logic [4:0]  mwb_rd,
  input  logic [31:0] mwb_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_read_out,
  output logic [31:0] pc_out,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t      state, state_n;

  // Held entry
  logic [31:0] e_pc, e_imm, e_rs1_data, e_rs2_data;
  logic [4:0]  e_rs1_addr, e_rs2_addr, e_rd;
  logic [3:0]  e_ctrl;
  logic        e_use_pc, e_use_imm, e_reg_write, e_mem_read;

  logic        accept, held, exm_load, hz_in, hz_held;
  logic        fwd_en, ex_fwd_ok, wb_fwd_ok;
  logic [31:0] rs1_fwd, rs2_fwd;

  assign in_ready  = (state == S_EMPTY) | ((state == S_FULL) & out_ready);
  assign out_valid = (state == S_FULL);
  assign state_dbg = state;

  // flush wins: a coincident in_valid is dropped even though in_ready is 1.
  assign accept = in_valid & in_ready & ~flush;

  // Entry stays put (and can absorb MEM/WB writes) unless it drains or is
  // flushed this edge.
  assign held = (((state == S_FULL) & ~out_ready) | (state == S_STALL)) & ~flush;

  // Load-use: a load in EX/MEM whose destination is an operand this entry
  // actually reads from the register file.
  assign exm_load = exm_reg_write & exm_mem_read & (exm_rd != 5'd0);
  assign hz_in    = exm_load & ((~use_pc   & (rs1_addr   == exm_rd)) |
                                (~use_imm  & (rs2_addr   == exm_rd)));
  assign hz_held  = exm_load & ((~e_use_pc & (e_rs1_addr == exm_rd)) |
                                (~e_use_imm & (e_rs2_addr == exm_rd)));

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) state_n = hz_in ? S_STALL : S_FULL;
        S_FULL: begin
          // A fresh entry arriving behind the drained one is still checked
          // against a load sitting in EX/MEM.
          if (out_ready) state_n = accept ? (hz_in ? S_STALL : S_FULL) : S_EMPTY;
        end
        S_STALL: if (!hz_held) state_n = S_FULL;
        default: state_n = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_n;
      if ((state == S_STALL) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_pc        <= 32'd0;
      e_imm       <= 32'd0;
      e_rs1_data  <= 32'd0;
      e_rs2_data  <= 32'd0;
      e_rs1_addr  <= 5'd0;
      e_rs2_addr  <= 5'd0;
      e_rd        <= 5'd0;
      e_ctrl      <= 4'd0;
      e_use_pc    <= 1'b0;
      e_use_imm   <= 1'b0;
      e_reg_write <= 1'b0;
      e_mem_read  <= 1'b0;
    end else if (accept) begin
      e_pc        <= pc;
      e_imm       <= imm;
      e_rs1_data  <= rs1_data;
      e_rs2_data  <= rs2_data;
      e_rs1_addr  <= rs1_addr;
      e_rs2_addr  <= rs2_addr;
      e_rd        <= rd_addr;
      e_ctrl      <= alu_ctrl_in;
      e_use_pc    <= use_pc;
      e_use_imm   <= use_imm;
      e_reg_write <= reg_write;
      e_mem_read  <= mem_read;
    end else if (held) begin
      // A writeback retiring while we wait would otherwise be lost once it
      // leaves MEM/WB; fold it into the stored operand.
      if (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == e_rs1_addr))
        e_rs1_data <= mwb_result;
      if (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == e_rs2_addr))
        e_rs2_data <= mwb_result;
    end
  end

  // Forwarding is disabled when EMPTY so the outputs hold the last captured
  // values instead of tracking producer traffic.
  assign fwd_en    = (state != S_EMPTY);
  assign ex_fwd_ok = fwd_en & exm_reg_write & ~exm_mem_read & (exm_rd != 5'd0);
  assign wb_fwd_ok = fwd_en & mwb_reg_write & (mwb_rd != 5'd0);

  always_comb begin
    rs1_fwd = e_rs1_data;
    rs2_fwd = e_rs2_data;
    if (ex_fwd_ok && (exm_rd == e_rs1_addr))      rs1_fwd = exm_result;
    else if (wb_fwd_ok && (mwb_rd == e_rs1_addr)) rs1_fwd = mwb_result;
    if (ex_fwd_ok && (exm_rd == e_rs2_addr))      rs2_fwd = exm_result;
    else if (wb_fwd_ok && (mwb_rd == e_rs2_addr)) rs2_fwd = mwb_result;
  end

  assign alu_a         = e_use_pc  ? e_pc  : rs1_fwd;
  assign alu_b         = e_use_imm ? e_imm : rs2_fwd;
  assign alu_ctrl      = e_ctrl;
  assign rd_out        = e_rd;
  assign reg_write_out = e_reg_write;
  assign mem_read_out  = e_mem_read;
  assign pc_out        = e_pc;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] pc, imm, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [3:0]  alu_ctrl_in;
  logic        use_pc, use_imm, reg_write, mem_read, flush;
  logic        exm_reg_write, exm_mem_read;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_result;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b, pc_out;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_read_out;
  logic [15:0] stall_cnt;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .imm(imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .alu_ctrl_in(alu_ctrl_in), .use_pc(use_pc), .use_imm(use_imm),
    .reg_write(reg_write), .mem_read(mem_read), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .pc_out(pc_out), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  logic [106:0] dut_vec;
  assign dut_vec = {alu_a, alu_b, alu_ctrl, rd_out, reg_write_out, mem_read_out, pc_out};

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  a1, a2, rd;
    logic [3:0]  ctrl;
    logic        upc, uimm, rw, mr;
  } ent_t;

  ent_t m_e;
  bit   m_have, m_stall;
  int   m_cnt;

  logic [106:0] exp_q[$];   // expected outputs at each ALU-side transfer
  logic [125:0] ctl_q[$];   // per-cycle {in_ready, out_valid, stall_cnt, empty, outputs}
  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    m_have = 0; m_stall = 0; m_cnt = 0;
    m_e = '{pc: 0, imm: 0, d1: 0, d2: 0, a1: 0, a2: 0, rd: 0, ctrl: 0,
            upc: 0, uimm: 0, rw: 0, mr: 0};
  endtask

  function automatic bit hz(ent_t e);
    if (!(exm_reg_write && exm_mem_read) || exm_rd == 0) return 0;
    return (!e.upc && e.a1 == exm_rd) || (!e.uimm && e.a2 == exm_rd);
  endfunction

  function automatic logic [31:0] fwd(logic [4:0] a, logic [31:0] d);
    if (a == 0) return d;
    if (exm_reg_write && !exm_mem_read && exm_rd == a) return exm_result;
    if (mwb_reg_write && mwb_rd == a) return mwb_result;
    return d;
  endfunction

  function automatic logic [106:0] outs(ent_t e, bit use_fwd);
    logic [31:0] a, b;
    a = e.upc  ? e.pc  : (use_fwd ? fwd(e.a1, e.d1) : e.d1);
    b = e.uimm ? e.imm : (use_fwd ? fwd(e.a2, e.d2) : e.d2);
    return {a, b, e.ctrl, e.rd, e.rw, e.mr, e.pc};
  endfunction

  function automatic ent_t in_ent();
    ent_t e;
    e.pc = pc; e.imm = imm; e.d1 = rs1_data; e.d2 = rs2_data;
    e.a1 = rs1_addr; e.a2 = rs2_addr; e.rd = rd_addr; e.ctrl = alu_ctrl_in;
    e.upc = use_pc; e.uimm = use_imm; e.rw = reg_write; e.mr = mem_read;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  // Called right after a falling edge with inputs already set; predicts this
  // cycle, advances the model, and returns at the next falling edge.
  task automatic do_cycle();
    bit ir, ov;
    logic [106:0] o;
    ent_t ne;
    #1;
    ir = !m_have || (!m_stall && out_ready);
    ov = m_have && !m_stall;
    o  = outs(m_e, m_have);
    ctl_q.push_back({ir, ov, m_cnt[15:0], !m_have, o});
    if (ov && out_ready) exp_q.push_back(o);
    if (m_have && m_stall && m_cnt < 65535) m_cnt++;
    if (flush) begin
      m_have = 0; m_stall = 0;
    end else if (in_valid && ir) begin
      ne = in_ent(); m_stall = hz(ne); m_e = ne; m_have = 1;
    end else if (ov && out_ready) begin
      m_have = 0;
    end else if (m_have) begin
      if (m_stall && !hz(m_e)) m_stall = 0;
      if (mwb_reg_write && mwb_rd != 0 && mwb_rd == m_e.a1) m_e.d1 = mwb_result;
      if (mwb_reg_write && mwb_rd != 0 && mwb_rd == m_e.a2) m_e.d2 = mwb_result;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_prod();
    exm_reg_write = 0; exm_mem_read = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0; flush = 0;
  endtask

  task automatic set_entry(input logic [31:0] p, input logic [31:0] im,
                           input logic [4:0] a1, input logic [31:0] d1,
                           input logic [4:0] a2, input logic [31:0] d2,
                           input logic [4:0] rd, input logic [3:0] ctl,
                           input logic upc, input logic uimm);
    pc = p; imm = im; rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2;
    rd_addr = rd; alu_ctrl_in = ctl; use_pc = upc; use_imm = uimm;
    reg_write = 1; mem_read = 0;
  endtask

  function automatic logic [4:0] pick();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      3: return 5'd3;
      default: return 5'd7;
    endcase
  endfunction

  task automatic rand_inputs();
    in_valid = ($urandom_range(0, 3) != 0);
    pc = $urandom; imm = $urandom; rs1_data = $urandom; rs2_data = $urandom;
    rs1_addr = pick(); rs2_addr = pick(); rd_addr = pick();
    alu_ctrl_in = 4'($urandom_range(0, 9));
    use_pc = ($urandom_range(0, 3) == 0); use_imm = ($urandom_range(0, 3) == 0);
    reg_write = ($urandom_range(0, 1) == 1); mem_read = ($urandom_range(0, 1) == 1);
    flush = ($urandom_range(0, 15) == 0);
    exm_reg_write = ($urandom_range(0, 9) < 6); exm_mem_read = ($urandom_range(0, 9) < 4);
    exm_rd = pick(); exm_result = $urandom;
    mwb_reg_write = ($urandom_range(0, 9) < 6); mwb_rd = pick(); mwb_result = $urandom;
    out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [125:0] c;
    forever begin
      @(negedge clk);
      #3;
      while (ctl_q.size() > 0) begin
        c = ctl_q.pop_front();
        chk("in_ready", in_ready, c[125]);
        chk("out_valid", out_valid, c[124]);
        chk("stall_cnt", stall_cnt, c[123:108]);
        if (c[107]) chk("empty_hold", dut_vec, c[106:0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL out_unexpected act=transfer exp=none t=%0t", $time);
        end else begin
          chk("out_data", dut_vec, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; in_valid = 0; out_ready = 0;
    set_entry(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_prod();
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 0;

    // Load-use stall, resolved by the load's writeback
    exm_reg_write = 1; exm_mem_read = 1; exm_rd = 7;
    set_entry(32'h10, 0, 5'd1, 32'h5, 5'd7, 32'h1234, 5'd9, 4'd0, 0, 0);
    in_valid = 1; out_ready = 1;
    do_cycle();
    idle_prod();
    mwb_reg_write = 1; mwb_rd = 7; mwb_result = 32'hDEAD;
    set_entry(32'h14, 0, 5'd2, 32'h6, 5'd3, 32'h7, 5'd4, 4'd0, 0, 0);
    #1;
    chk("stall_out_valid", out_valid, 0);
    chk("stall_in_ready", in_ready, 0);
    do_cycle();
    idle_prod(); in_valid = 0; out_ready = 0;
    #1;
    chk("unstall_out_valid", out_valid, 1);
    chk("unstall_alu_b", alu_b, 32'hDEAD);
    chk("unstall_stall_cnt", stall_cnt, 1);
    out_ready = 1;
    do_cycle();

    // Plain ADD, no producers
    set_entry(32'h40, 0, 5'd1, 32'd10, 5'd2, 32'd20, 5'd3, 4'b0000, 0, 0);
    in_valid = 1;
    do_cycle();
    in_valid = 0;
    #1;
    chk("add_out_valid", out_valid, 1);
    chk("add_alu_a", alu_a, 32'd10);
    chk("add_alu_b", alu_b, 32'd20);
    chk("add_alu_ctrl", alu_ctrl, 4'b0000);
    do_cycle();

    // Forwarding priority and x0
    set_entry(32'h100, 0, 5'd5, 32'h99, 5'd6, 32'h77, 5'd8, 4'd0, 0, 0);
    in_valid = 1; out_ready = 0;
    do_cycle();
    in_valid = 0;
    exm_reg_write = 1; exm_rd = 5; exm_result = 32'h11;
    mwb_reg_write = 1; mwb_rd = 5; mwb_result = 32'h22;
    #1;
    chk("fwd_exm_wins", alu_a, 32'h11);
    do_cycle();
    exm_rd = 0;
    #1;
    chk("fwd_mwb", alu_a, 32'h22);
    do_cycle();
    idle_prod(); out_ready = 1;
    do_cycle();
    set_entry(32'h104, 0, 5'd0, 32'h55, 5'd6, 32'h66, 5'd8, 4'd0, 0, 0);
    in_valid = 1;
    do_cycle();
    in_valid = 0;
    exm_reg_write = 1; exm_rd = 0; exm_result = 32'h11;
    mwb_reg_write = 1; mwb_rd = 0; mwb_result = 32'h22;
    #1;
    chk("fwd_x0", alu_a, 32'h55);
    do_cycle();
    idle_prod();

    // Backpressure then back-to-back transfer
    set_entry(32'h200, 0, 5'd1, 32'hA1, 5'd2, 32'hA2, 5'd3, 4'b1001, 0, 0);
    in_valid = 1; out_ready = 1;
    do_cycle();
    set_entry(32'h300, 0, 5'd1, 32'hB1, 5'd2, 32'hB2, 5'd3, 4'd2, 0, 0);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_alu_a", alu_a, 32'hA1);
      chk("bp_pc_out", pc_out, 32'h200);
      do_cycle();
    end
    out_ready = 1;
    do_cycle();
    in_valid = 0;
    #1;
    chk("b2b_alu_a", alu_a, 32'hB1);
    do_cycle();

    // Flush beats a coincident accept
    set_entry(32'h400, 0, 5'd1, 32'hC1, 5'd2, 32'hC2, 5'd3, 4'd1, 0, 0);
    in_valid = 1; out_ready = 0;
    do_cycle();
    set_entry(32'h500, 0, 5'd1, 32'hD1, 5'd2, 32'hD2, 5'd3, 4'd1, 0, 0);
    flush = 1; out_ready = 1;
    #1;
    chk("flush_in_ready", in_ready, 1);
    do_cycle();
    flush = 0; in_valid = 0;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_pc_hold", pc_out, 32'h400);
    do_cycle();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      do_cycle();
    end

    // Asynchronous reset in the middle of a stall
    idle_prod(); in_valid = 0; out_ready = 1;
    repeat (3) do_cycle();
    exm_reg_write = 1; exm_mem_read = 1; exm_rd = 7;
    set_entry(32'h600, 0, 5'd7, 32'h1, 5'd2, 32'h2, 5'd3, 4'd0, 0, 1);
    in_valid = 1;
    do_cycle();
    in_valid = 0;
    #1;
    chk("pre_rst_out_valid", out_valid, 0);
    chk("pre_rst_in_ready", in_ready, 0);
    #1;
    rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_pc_out", pc_out, 0);
    chk("arst_in_ready", in_ready, 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    idle_prod();
    set_entry(32'h700, 0, 5'd1, 32'h71, 5'd2, 32'h72, 5'd3, 4'd0, 0, 0);
    in_valid = 1;
    do_cycle();
    in_valid = 0;
    #1;
    chk("post_rst_alu_a", alu_a, 32'h71);
    do_cycle();
    do_cycle();

    @(negedge clk);
    #5;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-002 in_valid  input  1  decode-side entry valid; in_ready  output  1  stage can accept an entry this cycle.
REQ-003 pc, imm, rs1_data, rs2_data  input  32 each  decoded PC, immediate, and register-file read data.
REQ-004 rs1_addr, rs2_addr, rd_addr  input  5 each; alu_ctrl_in  input  4  ALU op (0000 ADD … 1001 AND, passed through unmodified).
REQ-005 use_pc, use_imm, reg_write, mem_read  input  1 each  A-source select, B-source select, writeback enable, load flag.
REQ-006 flush  input  1  discard held entry (branch redirect).
REQ-007 exm_reg_write, exm_mem_read  input  1 each; exm_rd  input  5; exm_result  input  32: EX/MEM producer.
REQ-008 mwb_reg_write  input  1; mwb_rd  input  5; mwb_result  input  32: MEM/WB producer.
REQ-009 out_valid  output  1; out_ready  input  1  ALU-side handshake.
REQ-010 alu_a, alu_b  output  32; alu_ctrl  output  4; rd_out  output  5; reg_write_out, mem_read_out  output  1; pc_out  output  32.
REQ-011 stall_cnt  output  16  saturating count of load-use stall cycles.

Function
REQ-012 One-entry register; states EMPTY, FULL, STALL; state encoding is internal.
REQ-013 in_ready SHALL be 1 in EMPTY, or in FULL when out_ready=1; 0 in STALL.
REQ-014 Accept when in_valid & in_ready: entry captured on that edge, out_valid not earlier than the next cycle (latency 1).
REQ-015 Load-use hazard: held entry reads a register (rs1 if !use_pc; rs2 if !use_imm) equal to exm_rd, exm_rd≠0, exm_reg_write=1, exm_mem_read=1.
REQ-016 Transitions: EMPTY→FULL on accept without hazard, EMPTY→STALL on accept with hazard; FULL→EMPTY on out_ready without accept; FULL→FULL on out_ready with accept; STALL→FULL when hazard clears; any→EMPTY on flush.
REQ-017 out_valid SHALL be 1 only in FULL; in STALL it SHALL be 0 and entry SHALL be held unchanged except REQ-020.
REQ-018 Forwarding (combinational at output, per operand): EX/MEM match (rd≠0, reg_write=1, mem_read=0) wins over MEM/WB match (rd≠0, reg_write=1); else stored data; register x0 never forwarded.
REQ-019 alu_a = use_pc ? pc : forwarded rs1; alu_b = use_imm ? imm : forwarded rs2; all 32-bit, no extension performed here.
REQ-020 While an entry is held (FULL not handshaking, or STALL), a MEM/WB write matching rs1_addr/rs2_addr (≠0) SHALL overwrite the stored rs1_data/rs2_data on that edge.
REQ-021 flush SHALL take priority over accept; an in_valid coincident with flush SHALL be dropped and in_ready SHALL still read per REQ-013.
REQ-022 stall_cnt SHALL increment by 1 on each clock edge spent in STALL and saturate at 16'hFFFF.
REQ-023 Outputs other than out_valid SHALL hold last captured values when EMPTY.

Reset
REQ-024 rst=1 SHALL immediately force state EMPTY, out_valid=0, all data outputs 0, stall_cnt=0, independent of clk.
REQ-025 rst asserted mid-STALL or mid-FULL SHALL discard the entry; first accept after release behaves per REQ-014.

Verification
REQ-026 Accept ADD, rs1_data=10, rs2_data=20, no producers, out_ready=1 -> next cycle out_valid=1, alu_a=10, alu_b=20, alu_ctrl=0000.
REQ-027 rs1_addr=5; exm_rd=5 result 0x11, mwb_rd=5 result 0x22 -> alu_a=0x11; with exm_rd=0 -> alu_a=0x22; rs1_addr=0 -> stored data, no forwarding.
REQ-028 Load in EX/MEM to x7, new entry rs2_addr=7 use_imm=0 -> STALL 1 cycle, out_valid=0, in_ready=0, stall_cnt=1; load leaves and writes x7=0xDEAD via MEM/WB -> FULL, alu_b=0xDEAD.
REQ-029 FULL with out_ready=0 for 3 cycles, then in_valid held -> entry and outputs stable, in_ready=0; out_ready=1 -> back-to-back accept of next entry.
REQ-030 flush with in_valid=1 in FULL -> next cycle EMPTY, out_valid=0, incoming entry dropped.
REQ-031 Assert rst asynchronously mid-STALL -> out_valid=0, stall_cnt=0 before the next clk edge.
